// File: rtl/vga_fb_arbiter.sv
// Purpose : arbitrates one single-port 1-bpp framebuffer RAM between VGA line prefetch (absolute
//           priority) and a pixel writer; ping-pong line buffers; serializes the current line to video.
// Latency : video 1 cycle after h_count/v_count; a line prefetch occupies h=640..681 of the previous line.
// Backpressure: the writer holds wr_req/wr_addr/wr_data until wr_ack; writes wait out a fetch, max 1 per 2 cycles.
//
// Ports: clk_25mhz/reset (sync, active-high); h_count/v_count from the 800x525 timing generator;
//        mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata to the RAM (read data returns the cycle after mem_rd);
//        wr_req/wr_addr/wr_data/wr_ack writer handshake; video pixel out; line_miss sticky underrun flag.
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int WORDS    = H_ACTIVE / 16
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        video,
    output logic        line_miss
);
    localparam int KW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [KW-1:0] k;          // next word index to issue
    logic [KW-1:0] rd_k;       // word index of the read currently on the RAM port
    logic [KW-1:0] cap_k;      // word index whose data is on mem_rdata this cycle
    logic          rd_q;       // mem_rdata carries fetch data this cycle
    logic          fsel;       // buffer being filled (target line bit 0)
    logic [14:0]   base;       // first RAM word of the target line
    logic [1:0]    valid;

    logic [15:0]   line_buf [2][WORDS];

    // Prefetch trigger at the start of hblank; the last active line and vblank have nothing to fetch,
    // except the final blank line, which fetches line 0 of the next frame.
    logic          trig;
    logic [9:0]    tgt;
    logic [14:0]   tgt_base;

    always_comb begin
        trig = 1'b0;
        tgt  = '0;
        if (h_count == 10'(H_ACTIVE)) begin
            if (v_count < 10'(V_ACTIVE - 1)) begin
                trig = 1'b1;
                tgt  = v_count + 10'd1;
            end else if (v_count == 10'(V_TOTAL - 1)) begin
                trig = 1'b1;
                tgt  = '0;
            end
        end
    end

    // t*40 without a multiplier
    assign tgt_base = ({5'd0, tgt} << 5) + ({5'd0, tgt} << 3);

    // Pixel lookup, MSB of each word is the leftmost pixel
    logic active;
    logic pix_bit;

    assign active = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));

    always_comb begin
        pix_bit = 1'b0;
        if (active) begin
            pix_bit = line_buf[v_count[0]][h_count[9:4]][4'd15 - h_count[3:0]];
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            rd_k      <= '0;
            cap_k     <= '0;
            rd_q      <= 1'b0;
            fsel      <= 1'b0;
            base      <= '0;
            valid     <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
            video     <= 1'b0;
            line_miss <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            wr_ack <= 1'b0;
            rd_q   <= mem_rd;
            cap_k  <= rd_k;

            case (state)
                IDLE: begin
                    if (trig) begin
                        // Word 0 goes out in the trigger cycle so the fetch finishes one cycle sooner
                        state        <= FETCH;
                        fsel         <= tgt[0];
                        base         <= tgt_base;
                        valid[tgt[0]] <= 1'b0;
                        mem_rd       <= 1'b1;
                        mem_addr     <= tgt_base;
                        rd_k         <= '0;
                        k            <= KW'(1);
                    end else if (wr_req && !wr_ack) begin
                        // The !wr_ack term keeps a still-held request from being issued twice
                        mem_wr    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                        wr_ack    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (k == KW'(WORDS)) begin
                        state <= DRAIN;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= base + 15'(k);
                        rd_k     <= k;
                        k        <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    // Last word lands in line_buf on this same edge
                    valid[fsel] <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            video <= active && valid[v_count[0]] && pix_bit;
            if (active && !valid[v_count[0]]) begin
                line_miss <= 1'b1;
            end
        end
    end

    // Line buffer storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk_25mhz) begin
        if (!reset && rd_q) begin
            line_buf[fsel][cap_k] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        video;
    logic        line_miss;

    logic        load_img = 1'b0;
    logic [15:0] ram [0:32767];

    int checks   = 0;
    int failures = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    vga_fb_arbiter dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .h_count   (h_count),
        .v_count   (v_count),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .video     (video),
        .line_miss (line_miss)
    );

    // Framebuffer image: line 0 patterned, word 40 = 8001, line 6 all ones, line 11 patterned.
    function automatic logic [15:0] img(input int a);
        logic [15:0] av;
        av = 16'(a);
        if (a < 40)                 return {av[7:0] ^ 8'h3C, 8'hA5};
        if (a == 40)                return 16'h8001;
        if (a >= 240 && a < 280)    return 16'hFFFF;
        if (a >= 440 && a < 480)    return {8'h5A, av[7:0]};
        return 16'h0000;
    endfunction

    // RAM model: synchronous read, data valid the cycle after mem_rd
    always @(posedge clk_25mhz) begin
        if (load_img) begin
            for (int i = 0; i < 32768; i++) ram[i] <= img(i);
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    function automatic logic exp_video(input int v, input int h);
        logic [15:0] w;
        if (v >= 480 || h >= 640) return 1'b0;
        w = img(v * 40 + h / 16);
        return w[15 - (h % 16)];
    endfunction

    function automatic logic exp_rd(input int v, input int h);
        return (h >= 640) && (h < 680) && ((v < 479) || (v == 524));
    endfunction

    function automatic logic [14:0] exp_raddr(input int v, input int h);
        int t;
        t = (v == 524) ? 0 : v + 1;
        return 15'(t * 40 + h - 640);
    endfunction

    task automatic tick();
        @(negedge clk_25mhz);
    endtask

    task automatic set_pos(input int v, input int h);
        v_count = 10'(v);
        h_count = 10'(h);
    endtask

    task automatic adv();
        if (h_count == 10'd799) begin
            h_count = 10'd0;
            v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count = h_count + 10'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        set_pos(524, 0);
        repeat (3) tick();
        checks++;
        if ({mem_rd, mem_wr, wr_ack, video, line_miss} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes got rd/wr/ack/video/miss=%b exp=00000",
                     {mem_rd, mem_wr, wr_ack, video, line_miss});
        end
        checks++;
        if (mem_addr !== 15'd0 || mem_wdata !== 16'd0) begin
            failures++;
            $display("FAIL reset_addr_data got addr=%0d wdata=%h exp addr=0 wdata=0000", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        load_img = 1'b1;
        tick();
        load_img = 1'b0;
    endtask

    // v=524 prefetches line 0, then lines 0 and 1 are displayed with no misses
    task automatic test_prefetch();
        int v, h;
        set_pos(524, 0);
        for (int n = 0; n < 2400; n++) begin
            tick();
            v = int'(v_count);
            h = int'(h_count);
            checks++;
            if (mem_rd !== exp_rd(v, h) || mem_wr !== 1'b0 || line_miss !== 1'b0 ||
                video !== exp_video(v, h)) begin
                failures++;
                $display("FAIL prefetch_cycle v=%0d h=%0d got rd=%b wr=%b miss=%b video=%b exp rd=%b wr=0 miss=0 video=%b",
                         v, h, mem_rd, mem_wr, line_miss, video, exp_rd(v, h), exp_video(v, h));
            end
            if (exp_rd(v, h)) begin
                checks++;
                if (mem_addr !== exp_raddr(v, h)) begin
                    failures++;
                    $display("FAIL prefetch_addr v=%0d h=%0d got=%0d exp=%0d", v, h, mem_addr, exp_raddr(v, h));
                end
            end
            if (v == 1 && (h == 0 || h == 15)) begin
                checks++;
                if (video !== 1'b1) begin
                    failures++;
                    $display("FAIL line1_edge_pixel h=%0d got=%b exp=1", h, video);
                end
            end
            adv();
        end
    endtask

    // Single write during active video on line 2, request held one extra cycle
    task automatic test_write();
        for (int n = 0; n < 100; n++) begin
            tick();
            adv();
        end
        wr_req = 1'b1;
        wr_addr = 15'd100;
        wr_data = 16'hFFFF;
        tick();
        checks++;
        if ({mem_wr, wr_ack, mem_rd} !== 3'b110 || mem_addr !== 15'd100 || mem_wdata !== 16'hFFFF) begin
            failures++;
            $display("FAIL write_issue got wr/ack/rd=%b addr=%0d wdata=%h exp 110 addr=100 wdata=ffff",
                     {mem_wr, wr_ack, mem_rd}, mem_addr, mem_wdata);
        end
        adv();
        tick();
        checks++;
        if ({mem_wr, wr_ack} !== 2'b00) begin
            failures++;
            $display("FAIL write_no_reissue got wr/ack=%b exp=00", {mem_wr, wr_ack});
        end
        wr_req = 1'b0;
        adv();
        for (int n = 0; n < 538; n++) begin
            tick();
            checks++;
            if (mem_wr !== 1'b0 || wr_ack !== 1'b0 || line_miss !== 1'b0 ||
                video !== exp_video(int'(v_count), int'(h_count))) begin
                failures++;
                $display("FAIL write_line2 h=%0d got wr=%b ack=%b miss=%b video=%b exp wr=0 ack=0 miss=0 video=%b",
                         h_count, mem_wr, wr_ack, line_miss, video, exp_video(int'(v_count), int'(h_count)));
            end
            adv();
        end
        checks++;
        if (ram[100] !== 16'hFFFF) begin
            failures++;
            $display("FAIL write_ram got=%h exp=ffff", ram[100]);
        end
    endtask

    // Write requested in the trigger cycle: fetch of 440..479 first, write right after DRAIN
    task automatic test_write_vs_fetch();
        int v, h;
        logic ew;
        set_pos(10, 640);
        wr_req = 1'b1;
        wr_addr = 15'd7;
        wr_data = 16'h1357;
        for (int n = 0; n < 800; n++) begin
            tick();
            v = int'(v_count);
            h = int'(h_count);
            ew = (v == 10 && h == 682);
            checks++;
            if ({mem_rd, mem_wr, wr_ack} !== {exp_rd(v, h), ew, ew}) begin
                failures++;
                $display("FAIL arb_cycle v=%0d h=%0d got rd/wr/ack=%b exp=%b", v, h,
                         {mem_rd, mem_wr, wr_ack}, {exp_rd(v, h), ew, ew});
            end
            checks++;
            if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                failures++;
                $display("FAIL arb_overlap v=%0d h=%0d got rd=1 wr=1 exp not both", v, h);
            end
            if (exp_rd(v, h)) begin
                checks++;
                if (mem_addr !== exp_raddr(v, h)) begin
                    failures++;
                    $display("FAIL arb_rd_addr h=%0d got=%0d exp=%0d", h, mem_addr, exp_raddr(v, h));
                end
            end
            if (ew) begin
                checks++;
                if (mem_addr !== 15'd7 || mem_wdata !== 16'h1357) begin
                    failures++;
                    $display("FAIL arb_wr_data got addr=%0d wdata=%h exp addr=7 wdata=1357", mem_addr, mem_wdata);
                end
            end
            checks++;
            if (line_miss !== 1'b0 || video !== exp_video(v, h)) begin
                failures++;
                $display("FAIL arb_video v=%0d h=%0d got miss=%b video=%b exp miss=0 video=%b",
                         v, h, line_miss, video, exp_video(v, h));
            end
            if (wr_ack === 1'b1) wr_req = 1'b0;
            adv();
        end
        wr_req = 1'b0;
    endtask

    // Reset during the line-6 fetch; the held write is acked after release; line 6 shows as missed
    task automatic test_reset_midfetch();
        int v, h;
        set_pos(5, 640);
        for (int n = 0; n < 20; n++) begin
            if (n == 10) begin
                wr_req = 1'b1;
                wr_addr = 15'd5000;
                wr_data = 16'h0F0F;
            end
            tick();
            checks++;
            if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== exp_raddr(5, int'(h_count))) begin
                failures++;
                $display("FAIL midfetch_pre h=%0d got rd=%b wr=%b addr=%0d exp rd=1 wr=0 addr=%0d",
                         h_count, mem_rd, mem_wr, mem_addr, exp_raddr(5, int'(h_count)));
            end
            adv();
        end
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({mem_rd, mem_wr, wr_ack, video, line_miss} !== 5'b0 || mem_addr !== 15'd0 ||
                mem_wdata !== 16'd0) begin
                failures++;
                $display("FAIL midfetch_reset h=%0d got rd/wr/ack/video/miss=%b addr=%0d wdata=%h exp all 0",
                         h_count, {mem_rd, mem_wr, wr_ack, video, line_miss}, mem_addr, mem_wdata);
            end
            adv();
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_wr, wr_ack, mem_rd} !== 3'b110 || mem_addr !== 15'd5000 || mem_wdata !== 16'h0F0F) begin
            failures++;
            $display("FAIL midfetch_write_after_reset got wr/ack/rd=%b addr=%0d wdata=%h exp 110 addr=5000 wdata=0f0f",
                     {mem_wr, wr_ack, mem_rd}, mem_addr, mem_wdata);
        end
        wr_req = 1'b0;
        adv();
        // now at v=5 h=664; run through the end of active line 6
        for (int n = 0; n < 776; n++) begin
            tick();
            v = int'(v_count);
            h = int'(h_count);
            checks++;
            if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || video !== 1'b0 || line_miss !== (v == 6)) begin
                failures++;
                $display("FAIL midfetch_line6 v=%0d h=%0d got rd=%b wr=%b video=%b miss=%b exp rd=0 wr=0 video=0 miss=%b",
                         v, h, mem_rd, mem_wr, video, line_miss, (v == 6));
            end
            adv();
        end
    endtask

    // No fetch in vblank; a continuously held writer is acked every second cycle
    task automatic test_vblank();
        logic exp_ack;
        int   acks;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (line_miss !== 1'b0) begin
            failures++;
            $display("FAIL vblank_miss_cleared got=%b exp=0", line_miss);
        end
        set_pos(479, 640);
        wr_req = 1'b1;
        wr_addr = 15'd200;
        wr_data = 16'd1;
        exp_ack = 1'b1;
        acks = 0;
        for (int n = 0; n < 320; n++) begin
            if (n == 160) set_pos(500, 640);
            tick();
            checks++;
            if (mem_rd !== 1'b0 || wr_ack !== exp_ack || mem_wr !== exp_ack) begin
                failures++;
                $display("FAIL vblank_cycle v=%0d h=%0d got rd=%b ack=%b wr=%b exp rd=0 ack=%b wr=%b",
                         v_count, h_count, mem_rd, wr_ack, mem_wr, exp_ack, exp_ack);
            end
            if (exp_ack) begin
                checks++;
                if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin
                    failures++;
                    $display("FAIL vblank_wr_data got addr=%0d wdata=%h exp addr=%0d wdata=%h",
                             mem_addr, mem_wdata, wr_addr, wr_data);
                end
            end
            if (wr_ack === 1'b1) begin
                acks++;
                wr_addr = wr_addr + 15'd1;
                wr_data = wr_data + 16'd1;
            end
            exp_ack = ~exp_ack;
            adv();
        end
        wr_req = 1'b0;
        tick();
        checks++;
        if (acks !== 160) begin
            failures++;
            $display("FAIL vblank_ack_count got=%0d exp=160", acks);
        end
        checks++;
        if (ram[359] !== 16'd160 || ram[5000] !== 16'h0F0F || ram[7] !== 16'h1357) begin
            failures++;
            $display("FAIL vblank_ram got ram359=%h ram5000=%h ram7=%h exp 00a0 0f0f 1357",
                     ram[359], ram[5000], ram[7]);
        end
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_write();
        test_write_vs_fetch();
        test_reset_midfetch();
        test_vblank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
